// File: rtl/conv_proc_element.sv
// -----------------------------------------------------------------------------
// conv_proc_element
//   Pipelined 3x3 pixel processing element. Each cycle it may accept one 3x3
//   window of RGB444 pixels, apply either the programmable signed kernel or a
//   per-pixel mode to every 4-bit channel, and emit one result pixel with a
//   write strobe three cycles later. Throughput is one pixel per cycle with no
//   stall.
//
//   Handshake: valid-only streaming, no back-pressure. A window is consumed on
//   every rising edge where valid_in=1; its result appears with we_out=1 for
//   exactly one cycle, in input order. wdata_out holds between results.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   valid_in       window on row0_in..row2_in valid this cycle
//   mode           00 conv, 01 bypass centre, 10 grayscale, 11 invert centre
//   row0..2_in     window rows {x-1, x, x+1}, 12 bits per pixel {R,G,B}
//   kernel_we      kernel register write strobe
//   kernel_idx     0..8 coefficient (row-major, 4 = centre), 9 = shift
//   kernel_wdata   signed coefficient, or shift amount in [2:0]
//   we_out         result valid (write enable of the data accumulator)
//   wdata_out      result pixel
//   busy           valid_in or any pipeline stage holds data
//   kernel_err     one-cycle pulse when a kernel write was dropped
// -----------------------------------------------------------------------------
module conv_proc_element #(
   parameter int PIX_W  = 12,
   parameter int COEF_W = 4,
   parameter int LAT    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in,
   input  logic [1:0]           mode,
   input  logic [3*PIX_W-1:0]   row0_in,
   input  logic [3*PIX_W-1:0]   row1_in,
   input  logic [3*PIX_W-1:0]   row2_in,
   input  logic                 kernel_we,
   input  logic [3:0]           kernel_idx,
   input  logic [COEF_W-1:0]    kernel_wdata,
   output logic                 we_out,
   output logic [PIX_W-1:0]     wdata_out,
   output logic                 busy,
   output logic                 kernel_err
);

   localparam int CH_W   = PIX_W / 3;
   localparam int PROD_W = COEF_W + CH_W;   // signed coef x unsigned channel
   localparam int SUM_W  = PROD_W + 4;      // nine products
   localparam logic [1:0] MODE_CONV   = 2'b00;
   localparam logic [1:0] MODE_BYPASS = 2'b01;
   localparam logic [1:0] MODE_GRAY   = 2'b10;
   localparam logic [1:0] MODE_INVERT = 2'b11;

   // ---------------- kernel registers ----------------
   logic signed [COEF_W-1:0] coef_q [9];
   logic signed [COEF_W-1:0] coef_d [9];
   logic [2:0]               shift_q, shift_d;
   logic                     kernel_err_q, kernel_err_d;

   // ---------------- pipeline registers ----------------
   // vld_q[0] = S1, vld_q[LAT-2] = S2, vld_q[LAT-1] = S3 (we_out)
   logic [LAT-1:0]           vld_q, vld_d;

   logic signed [PROD_W-1:0] prod_q [3][9];
   logic signed [PROD_W-1:0] prod_d [3][9];
   logic [PIX_W-1:0]         center1_q, center1_d;
   logic [1:0]               mode1_q, mode1_d;
   logic [2:0]               shift1_q, shift1_d;

   logic signed [SUM_W-1:0]  sum_q [3];
   logic signed [SUM_W-1:0]  sum_d [3];
   logic [CH_W-1:0]          gray_q, gray_d;
   logic [PIX_W-1:0]         center2_q, center2_d;
   logic [1:0]               mode2_q, mode2_d;
   logic [2:0]               shift2_q, shift2_d;

   logic [PIX_W-1:0]         wdata_q, wdata_d;

   // ---------------- combinational helpers ----------------
   logic [3*PIX_W-1:0]       rows [3];
   logic [PIX_W-1:0]         win [9];
   logic signed [SUM_W-1:0]  sh;
   logic [CH_W-1:0]          ch_res;
   logic [PIX_W-1:0]         conv_pix;
   logic [PIX_W-1:0]         result;

   assign busy = valid_in | (|vld_q);

   // Kernel writes are only taken while the pipeline is empty so a whole image
   // sees one kernel; a write attempted while busy is dropped and flagged.
   always_comb begin
      coef_d       = coef_q;
      shift_d      = shift_q;
      kernel_err_d = 1'b0;
      if (kernel_we) begin
         if (busy) begin
            kernel_err_d = 1'b1;
         end else if (kernel_idx < 4'd9) begin
            coef_d[kernel_idx] = kernel_wdata;
         end else if (kernel_idx == 4'd9) begin
            shift_d = kernel_wdata[2:0];
         end
      end
   end

   // S1: per-tap, per-channel products
   always_comb begin
      rows[0] = row0_in;
      rows[1] = row1_in;
      rows[2] = row2_in;
      for (int k = 0; k < 9; k++) begin
         win[k] = rows[k / 3][3*PIX_W-1-PIX_W*(k % 3) -: PIX_W];
      end
      for (int ch = 0; ch < 3; ch++) begin
         for (int k = 0; k < 9; k++) begin
            prod_d[ch][k] = PROD_W'(coef_q[k]) *
                            PROD_W'($signed({1'b0, win[k][PIX_W-1-CH_W*ch -: CH_W]}));
         end
      end
      center1_d = row1_in[2*PIX_W-1:PIX_W];
      mode1_d   = mode;
      shift1_d  = shift_q;
      vld_d     = {vld_q[LAT-2:0], valid_in};
   end

   // S2: channel sums and grayscale level of the centre pixel
   always_comb begin
      for (int ch = 0; ch < 3; ch++) begin
         sum_d[ch] = '0;
         for (int k = 0; k < 9; k++) begin
            sum_d[ch] = sum_d[ch] + SUM_W'(prod_q[ch][k]);
         end
      end
      gray_d = CH_W'(((CH_W+2)'(center1_q[PIX_W-1 -: CH_W]) +
                      (CH_W+2)'({center1_q[2*CH_W-1 -: CH_W], 1'b0}) +
                      (CH_W+2)'(center1_q[CH_W-1:0])) >> 2);
      center2_d = center1_q;
      mode2_d   = mode1_q;
      shift2_d  = shift1_q;
   end

   // S3: shift, clamp to 0..15 and select the mode result
   always_comb begin
      sh       = '0;
      ch_res   = '0;
      conv_pix = '0;
      for (int ch = 0; ch < 3; ch++) begin
         sh = sum_q[ch] >>> shift2_q;
         if (sh[SUM_W-1]) begin
            ch_res = '0;
         end else if (|sh[SUM_W-2:CH_W]) begin
            ch_res = '1;
         end else begin
            ch_res = sh[CH_W-1:0];
         end
         conv_pix[PIX_W-1-CH_W*ch -: CH_W] = ch_res;
      end
      case (mode2_q)
         MODE_CONV:   result = conv_pix;
         MODE_BYPASS: result = center2_q;
         MODE_GRAY:   result = {3{gray_q}};
         MODE_INVERT: result = ~center2_q;   // 15-c on every 4-bit channel
         default:     result = conv_pix;
      endcase
      wdata_d = wdata_q;
      if (vld_q[LAT-2]) begin
         wdata_d = result;
      end
   end

   // Control state: reset to empty pipeline and identity kernel.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q        <= '0;
         wdata_q      <= '0;
         kernel_err_q <= 1'b0;
         shift_q      <= '0;
         for (int k = 0; k < 9; k++) begin
            coef_q[k] <= (k == 4) ? COEF_W'(1) : '0;
         end
      end else begin
         vld_q        <= vld_d;
         wdata_q      <= wdata_d;
         kernel_err_q <= kernel_err_d;
         shift_q      <= shift_d;
         coef_q       <= coef_d;
      end
   end

   // Datapath registers: qualified by the valid bits, no reset needed.
   always_ff @(posedge clk) begin
      prod_q    <= prod_d;
      center1_q <= center1_d;
      mode1_q   <= mode1_d;
      shift1_q  <= shift1_d;
      sum_q     <= sum_d;
      gray_q    <= gray_d;
      center2_q <= center2_d;
      mode2_q   <= mode2_d;
      shift2_q  <= shift2_d;
   end

   assign we_out     = vld_q[LAT-1];
   assign wdata_out  = wdata_q;
   assign kernel_err = kernel_err_q;

endmodule
